draw_arbiter: RTL

DRAW_ARBITER -- requirements
Module: draw_arbiter

---
 rtl/draw_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 32 +++
 rtl/draw_arbiter.sv | 112 +++++++++++
 3 files changed

// File: rtl/draw_arb_pkg.sv
// Shared types and constants for the drawer-to-framebuffer arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package draw_arb_pkg;

    localparam int N_REQ        = 4;
    localparam int MAX_HOLD_DEF = 20000;
    localparam int X_W          = 8;
    localparam int Y_W          = 7;
    localparam int C_W          = 3;
    localparam int HOLD_W       = 15;
    localparam int IDX_W        = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_RELEASE
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner select: first active request after last_grant, wrapping.
// Latency: combinational.
// Backpressure: none; result is only used by the caller when a request is present.
module rr_picker
    import draw_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] grant_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    // k = N_REQ wraps back to last_grant itself, so it is searched last
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = last_grant + IDX_W'(k);
            if (!found && req[cand]) begin
                found          = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/draw_arbiter.sv
// Arbitrates N_REQ pixel drawers onto one framebuffer write port, round-robin, no pre-emption.
// Latency: grant one cycle after request; pixel reaches vga outputs one cycle after its strobe.
// Backpressure: ungranted drawers stall; a grant is force-released after MAX_HOLD cycles.
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int N_REQ    = draw_arb_pkg::N_REQ,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req_active,
    input  logic [N_REQ*X_W-1:0]   req_x,
    input  logic [N_REQ*Y_W-1:0]   req_y,
    input  logic [N_REQ*C_W-1:0]   req_colour,
    input  logic [N_REQ-1:0]       req_write,
    output logic [N_REQ-1:0]       grant,
    output logic [X_W-1:0]         vga_x,
    output logic [Y_W-1:0]         vga_y,
    output logic [C_W-1:0]         vga_colour,
    output logic                   vga_plot,
    output logic                   busy,
    output logic                   timeout_err
);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] g_idx, last_grant, pick_idx;
    logic [N_REQ-1:0] pick_oh;
    logic [HOLD_W-1:0] hold_cnt;
    logic             any_req, g_active, hold_max;
    logic             do_grant, do_pix, leave_grant, set_to, do_release;

    assign any_req  = |req_active;
    assign g_active = req_active[g_idx];
    assign hold_max = (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    assign busy     = (state != ST_IDLE);

    rr_picker u_pick (
        .req        (req_active),
        .last_grant (last_grant),
        .grant_oh   (pick_oh),
        .grant_idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (any_req) state_nxt = ST_GRANT;
            ST_GRANT:   if (!g_active || hold_max) state_nxt = ST_RELEASE;
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        do_grant    = 1'b0;
        do_pix      = 1'b0;
        leave_grant = 1'b0;
        set_to      = 1'b0;
        do_release  = 1'b0;
        case (state)
            ST_IDLE:    do_grant = any_req;
            ST_GRANT: begin
                do_pix      = 1'b1;
                leave_grant = !g_active || hold_max;
                set_to      = g_active && hold_max;
            end
            ST_RELEASE: do_release = 1'b1;
            default:    ;
        endcase
    end

    // Outputs are registers so an async reset clears them without waiting for clk
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant       <= '0;
            g_idx       <= '0;
            last_grant  <= '1;
            hold_cnt    <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_plot    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            vga_plot <= 1'b0;
            if (do_grant) begin
                grant    <= pick_oh;
                g_idx    <= pick_idx;
                hold_cnt <= '0;
            end
            if (do_pix) begin
                vga_plot <= req_write[g_idx];
                if (req_write[g_idx]) begin
                    vga_x      <= req_x[int'(g_idx)*X_W +: X_W];
                    vga_y      <= req_y[int'(g_idx)*Y_W +: Y_W];
                    vga_colour <= req_colour[int'(g_idx)*C_W +: C_W];
                end
                if (hold_cnt != '1) hold_cnt <= hold_cnt + 1'b1;
                if (leave_grant) grant <= '0;
            end
            if (set_to)     timeout_err <= 1'b1;
            if (do_release) last_grant  <= g_idx;
        end
    end

endmodule
